// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, reads the
// combinational instruction memory, and holds fetched words in a
// 2-entry FIFO that the decoder drains through a valid/ready handshake.
// A redirect reloads the PC and flushes the FIFO. Fetching stops once
// the PC runs past the last legal word of instruction memory.
module instr_fetch #(
  parameter int unsigned           bus_length = 64,
  parameter logic [bus_length-1:0] RESET_PC   = '0,
  parameter int unsigned           MEM_BYTES  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [bus_length-1:0] read_address,
  input  logic [31:0]           instruction,
  input  logic                  redirect_valid,
  input  logic [bus_length-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [bus_length-1:0] out_pc,
  output logic                  fetch_oob,
  output logic                  misalign_err,
  output logic [31:0]           fetch_count
);

  // Highest byte address from which a full 32-bit word can still be fetched.
  localparam logic [bus_length-1:0] LAST_ADDR_C = bus_length'(MEM_BYTES - 32'd4);
  localparam logic [bus_length-1:0] STEP_C      = bus_length'(32'd4);

  logic [bus_length-1:0] pc_r;
  logic [bus_length-1:0] buf_pc_r    [2];
  logic [31:0]           buf_instr_r [2];
  logic                  rd_ptr_r;
  logic                  wr_ptr_r;
  logic [1:0]            count_r;
  logic                  fetch_oob_r;
  logic                  misalign_err_r;
  logic [31:0]           fetch_count_r;

  logic                  pop_s;
  logic                  oob_now_s;
  logic                  can_fetch_s;

  // Handshake and fetch-permission decode. A full buffer may still
  // accept a new word when the head leaves in the same cycle.
  always_comb begin
    pop_s       = 1'b0;
    oob_now_s   = 1'b0;
    can_fetch_s = 1'b0;
    pop_s       = (count_r != 2'd0) & out_ready;
    oob_now_s   = (pc_r > LAST_ADDR_C);
    can_fetch_s = ~redirect_valid & ~oob_now_s & ((count_r < 2'd2) | pop_s);
  end

  // Program counter: reset, redirect (word-aligned), sequential advance, or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= {redirect_pc[bus_length-1:2], 2'b00};
    end else if (can_fetch_s) begin
      pc_r <= pc_r + STEP_C;
    end else begin
      pc_r <= pc_r;
    end
  end

  // FIFO storage, pointers and occupancy; a redirect drops all entries
  // and any pop that coincides with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_pc_r[i]    <= '0;
        buf_instr_r[i] <= 32'h0000_0000;
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (redirect_valid) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (can_fetch_s) begin
        buf_pc_r[wr_ptr_r]    <= pc_r;
        buf_instr_r[wr_ptr_r] <= instruction;
        wr_ptr_r              <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({can_fetch_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Status: delayed out-of-bounds flag, sticky misalignment, enqueue counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_oob_r    <= 1'b0;
      misalign_err_r <= 1'b0;
      fetch_count_r  <= 32'd0;
    end else begin
      fetch_oob_r <= oob_now_s;
      if (redirect_valid) begin
        misalign_err_r <= misalign_err_r | (redirect_pc[1:0] != 2'b00);
      end else begin
        misalign_err_r <= misalign_err_r;
      end
      if (can_fetch_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end else begin
        fetch_count_r <= fetch_count_r;
      end
    end
  end

  assign read_address = pc_r;
  assign out_valid    = (count_r != 2'd0);
  assign out_instr    = buf_instr_r[rd_ptr_r];
  assign out_pc       = buf_pc_r[rd_ptr_r];
  assign fetch_oob    = fetch_oob_r;
  assign misalign_err = misalign_err_r;
  assign fetch_count  = fetch_count_r;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that sits directly upstream of the instruction memory and feeds the decoder.
- Holds the program counter and drives the byte address into the combinational instruction memory (mem_instr).
- Captures each returned 32-bit instruction together with its PC into a 2-entry buffer, which the decoder drains through a valid/ready handshake.
- Handles branch/jump redirects with a buffer flush, and stops fetching past the end of instruction memory.

Parameters:
- bus_length, 64: width of PC and memory address.
- RESET_PC, 0: PC value loaded on reset.
- MEM_BYTES, 256: instruction memory size in bytes; the last legal fetch address is MEM_BYTES-4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- read_address  output  bus_length  byte address to instruction memory; always equals the current PC.
- instruction  input  32  word returned combinationally by instruction memory for read_address.
- redirect_valid  input  1  taken branch/jump this cycle.
- redirect_pc  input  bus_length  redirect target byte address.
- out_valid  output  1  buffer head holds a valid instruction.
- out_ready  input  1  decoder accepts the head this cycle.
- out_instr  output  32  head instruction.
- out_pc  output  bus_length  PC of the head instruction.
- fetch_oob  output  1  PC is beyond MEM_BYTES-4; fetching is stopped.
- misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].
- fetch_count  output  32  number of instructions enqueued since reset; wraps.

Behaviour:
- Reset, applied on a clk edge with reset=1, sets:
  - pc=RESET_PC
  - buffer empty (count=0, rd_ptr=wr_ptr=0)
  - out_valid=0, out_instr=0, out_pc=0
  - fetch_oob=0, misalign_err=0, fetch_count=0
- Reset has priority over every other input, including a redirect in the same cycle. Reset mid-stream discards all buffered entries.
- read_address = pc, combinationally. The instruction input is valid in the same cycle.
- pop = out_valid & out_ready.
- can_fetch = !redirect_valid & !oob_now & (count<2 | pop), where oob_now = (pc > MEM_BYTES-4).
- On a can_fetch cycle:
  - write {pc, instruction} at wr_ptr.
  - pc <= pc+4; the addition is modulo 2^bus_length.
  - fetch_count increments by 1.
- Buffer is a 2-entry circular FIFO with 1-bit pointers.
  - The count update accounts for simultaneous push and pop: count is unchanged when both occur, and a push into a full buffer is legal only when a pop occurs in the same cycle.
  - out_valid = (count!=0). out_instr/out_pc are driven from the entry at rd_ptr (registered storage).
  - First-instruction latency: out_valid rises 1 cycle after the fetch edge. With out_ready held at 1, one instruction per cycle is sustained.
- Redirect (redirect_valid=1, not in reset):
  - pc <= {redirect_pc[bus_length-1:2], 2'b00}.
  - Buffer is flushed: count=0, pointers=0. out_valid=0 on the next cycle.
  - No enqueue that cycle. A pop in the same cycle is ignored for decoder bookkeeping, because the flushed entry is dropped.
  - misalign_err <= misalign_err | (redirect_pc[1:0]!=0).
- Out-of-bounds:
  - fetch_oob is a registered copy of oob_now, updated every cycle, so it reflects the current PC one cycle later.
  - While out of bounds, pc holds and nothing is enqueued. Buffered entries still drain normally.
  - A redirect to a legal address clears the condition; fetching resumes on the cycle after the redirect.
- Backpressure: while out_ready=0 and count=2, pc holds and read_address stays stable.
- Every output is a register or a direct function of registers except read_address (which is pc). No combinational path exists from out_ready to read_address.

Test Plan:
- Reset then stream:
  - Memory model returns 0x001101B3 at 0 and 0x401101B3 at 4; reset=1 for 2 cycles, then out_ready=1.
  - Required: out_valid=1 one cycle after reset release, out_pc=0, out_instr=0x001101B3.
  - Required on the next cycle: out_pc=4, out_instr=0x401101B3.
  - Required: fetch_count increments by 1 per cycle.
- Backpressure:
  - out_ready=0 from reset.
  - Required: after 2 fetches count=2, pc=8, and read_address holds 8.
  - Then raise out_ready for 1 cycle. Required: the entry with PC 0 pops, PC 8 enqueues, and pc=12.
- Redirect with flush:
  - Redirect in the same cycle as buffered entries, with redirect_pc=0x18.
  - Required next cycle: out_valid=0, read_address=0x18.
  - Required the following cycle: out_pc=0x18.
  - Required: misalign_err stays 0.
- Misaligned redirect:
  - redirect_pc=0x1A.
  - Required: pc becomes 0x18 and misalign_err=1, sticky until reset.
- End of memory:
  - Redirect to 0xFC with MEM_BYTES=256.
  - Required: 0xFC is fetched, then pc=0x100 holds and fetch_oob=1. No further enqueues occur and fetch_count stops.
  - Redirect to 0. Required: fetch_oob=0 and fetching resumes.
- Reset mid-operation and priority:
  - Assert reset together with redirect_valid while count=2.
  - Required: pc=RESET_PC, out_valid=0, fetch_count=0.
